sprite_blitter: RTL

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sprite_blitter.sv
// XOR sprite blitter for a 1bpp framebuffer with 64x32 and 128x64 modes.
// One sprite row per pass: fetch bytes, shift into a 2-word span, read-XOR-write.
module sprite_blitter #(
  parameter int FB_WORDS = 512
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic        hires,
  input  logic [6:0]  pos_x,
  input  logic [5:0]  pos_y,
  input  logic [3:0]  rows,
  input  logic [11:0] sprite_base,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [8:0]  fb_addr,
  input  logic [15:0] fb_rdata,
  output logic [15:0] fb_wdata,
  output logic        fb_we,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  typedef enum logic [3:0] {
    IDLE, FETCH_HI, FETCH_LO, LATCH,
    RD0, WR0, RD1, WR1, DONE
  } state_t;

  state_t state, state_nx;

  logic        hr;
  logic        wide;
  logic [6:0]  x_r;
  logic [5:0]  y_r;
  logic [4:0]  left;
  logic [7:0]  hi_byte;
  logic [31:0] span;

  logic [4:0]  h_in;
  logic        last_row;
  logic        b_on;
  logic        go_b;
  logic [15:0] word_a;
  logic [15:0] word_b;
  logic [8:0]  addr_a;
  logic [8:0]  addr_b;
  logic [15:0] row16;

  assign h_in = (hires && rows == 4'd0) ? 5'd16 : {1'b0, rows};
  assign last_row = (left == 5'd1) ||
                    (hr ? (y_r == 6'd63) : (y_r[4:0] == 5'd31));
  assign b_on = hr ? (x_r[6:4] != 3'd7) : (x_r[5:4] != 2'd3);
  assign word_a = span[31:16];
  assign word_b = span[15:0];
  assign go_b = (word_b != 16'd0) && b_on;
  assign addr_a = hr ? {y_r, x_r[6:4]}
                     : {2'b00, y_r[4:0], x_r[5:4]};
  assign addr_b = addr_a + 9'd1;
  assign row16 = wide ? {hi_byte, mem_rdata} : {mem_rdata, 8'h00};

  always_ff @(posedge clk) begin
    if (res) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start) state_nx = (h_in == 5'd0) ? DONE : FETCH_HI;
      FETCH_HI: state_nx = wide ? FETCH_LO : LATCH;
      FETCH_LO: state_nx = LATCH;
      LATCH:    state_nx = RD0;
      RD0:      state_nx = WR0;
      WR0: begin
        if (go_b)          state_nx = RD1;
        else if (last_row) state_nx = DONE;
        else               state_nx = FETCH_HI;
      end
      RD1:      state_nx = WR1;
      WR1:      state_nx = last_row ? DONE : FETCH_HI;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = 1'b0;
    fb_we    = 1'b0;
    fb_addr  = 9'd0;
    fb_wdata = 16'd0;
    unique case (state)
      RD0: fb_addr = addr_a;
      WR0: begin
        fb_addr  = addr_a;
        fb_wdata = fb_rdata ^ word_a;
        fb_we    = ({23'd0, addr_a} < 32'(FB_WORDS));
      end
      RD1: fb_addr = addr_b;
      WR1: begin
        fb_addr  = addr_b;
        fb_wdata = fb_rdata ^ word_b;
        fb_we    = ({23'd0, addr_b} < 32'(FB_WORDS));
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // mem_addr ends each row at its last byte, so +1 steps to the next row.
  always_ff @(posedge clk) begin
    if (res) begin
      hr        <= 1'b0;
      wide      <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      left      <= '0;
      hi_byte   <= '0;
      span      <= '0;
      mem_addr  <= '0;
      collision <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          hr        <= hires;
          wide      <= hires && (rows == 4'd0);
          x_r       <= hires ? pos_x : {1'b0, pos_x[5:0]};
          y_r       <= hires ? pos_y : {1'b0, pos_y[4:0]};
          left      <= h_in;
          mem_addr  <= sprite_base;
          collision <= 1'b0;
        end
        FETCH_HI: if (wide) mem_addr <= mem_addr + 12'd1;
        FETCH_LO: hi_byte <= mem_rdata;
        LATCH:    span <= {row16, 16'h0000} >> x_r[3:0];
        WR0: begin
          if ((fb_rdata & word_a) != 16'd0) collision <= 1'b1;
          if (!go_b && !last_row) begin
            y_r      <= y_r + 6'd1;
            left     <= left - 5'd1;
            mem_addr <= mem_addr + 12'd1;
          end
        end
        WR1: begin
          if ((fb_rdata & word_b) != 16'd0) collision <= 1'b1;
          if (!last_row) begin
            y_r      <= y_r + 6'd1;
            left     <= left - 5'd1;
            mem_addr <= mem_addr + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
